// File: rtl/reg_apb_bridge.sv
// reg_apb_bridge: APB3 slave front-end for the register bank.
// Decodes paddr[15:12] into a sub-block index and paddr[11:0] into a sub-register
// address, pulses a one-hot write enable, and returns the selected sub-block's read
// data after one fixed wait state.
// Optional feature: define REG_BRIDGE_PSLVERR_EN to report unmapped accesses on pslverr.
// Without it, unmapped accesses complete normally. In both builds they read as zero
// and never write.
module reg_apb_bridge #(
    parameter int NSUB = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [15:0]          paddr,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [11:0]          sub_reg_addr,
    output logic [31:0]          reg_wr_data,
    output logic [NSUB-1:0]      reg_wr_en,
    input  logic [32*NSUB-1:0]   reg_rd_data_bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state_q,   state_d;
    logic [31:0]       prdata_q,  prdata_d;
    logic              pready_q,  pready_d;
    logic              pslverr_q, pslverr_d;
    logic [11:0]       addr_q,    addr_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [NSUB-1:0]   wr_en_q,   wr_en_d;
    logic [3:0]        idx_q,     idx_d;
    logic              dir_q,     dir_d;
    logic              err_q,     err_d;
    logic [31:0]       rd_sel;

    // Select the read word of the sub-block latched at setup (zero if out of range)
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NSUB; i++) begin
            if (idx_q == 4'(i)) begin
                rd_sel = reg_rd_data_bus[i*32 +: 32];
            end
        end
    end

    // Next-state and next-output logic for the IDLE -> ISSUE -> RESP transfer sequence
    always_comb begin
        state_d   = state_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_en_d   = '0;
        idx_d     = idx_q;
        dir_d     = dir_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr[11:0];
                    wdata_d = pwdata;
                    idx_d   = paddr[15:12];
                    dir_d   = pwrite;
                    err_d   = ({1'b0, paddr[15:12]} >= 5'(NSUB));
                    for (int i = 0; i < NSUB; i++) begin
                        wr_en_d[i] = pwrite && (paddr[15:12] == 4'(i));
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    if (!dir_q) begin
                        prdata_d = err_q ? 32'h0 : rd_sel;
                    end
                    pready_d = 1'b1;
`ifdef REG_BRIDGE_PSLVERR_EN
                    pslverr_d = err_q;
`else
                    pslverr_d = 1'b0;
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state register for the FSM and every registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_en_q   <= '0;
            idx_q     <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_en_q   <= wr_en_d;
            idx_q     <= idx_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
        end
    end

    assign prdata       = prdata_q;
    assign pready       = pready_q;
    assign pslverr      = pslverr_q;
    assign sub_reg_addr = addr_q;
    assign reg_wr_data  = wdata_q;
    assign reg_wr_en    = wr_en_q;

endmodule

// File: tb/tb_reg_apb_bridge.sv
// tb_reg_apb_bridge: scoreboard bench for reg_apb_bridge with a behavioural sub-block model.
// The expected pslverr follows REG_BRIDGE_PSLVERR_EN, the same define the RTL is built with.
module tb_reg_apb_bridge;

    localparam int NSUB = 4;
`ifdef REG_BRIDGE_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic            dir;
        logic [15:0]     addr;
        logic [31:0]     wdata;
        logic [31:0]     rdata;
        logic            err;
        logic [NSUB-1:0] wr_en;
    } txn_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                psel, penable, pwrite;
    logic [15:0]         paddr;
    logic [31:0]         pwdata;
    logic [31:0]         prdata;
    logic                pready, pslverr;
    logic [11:0]         sub_reg_addr;
    logic [31:0]         reg_wr_data;
    logic [NSUB-1:0]     reg_wr_en;
    logic [32*NSUB-1:0]  reg_rd_data_bus;

    logic [31:0] mem    [NSUB][16];
    logic [31:0] shadow [NSUB][16];
    logic [31:0] last_rd;
    txn_t        sbq[$];
    int          checks = 0;
    int          errors = 0;

    reg_apb_bridge #(.NSUB(NSUB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr),
        .sub_reg_addr    (sub_reg_addr),
        .reg_wr_data     (reg_wr_data),
        .reg_wr_en       (reg_wr_en),
        .reg_rd_data_bus (reg_rd_data_bus)
    );

    always #5 clk = ~clk;

    // Sub-block model: combinational read from sub_reg_addr, write sampled on the clock edge
    always_comb begin
        for (int i = 0; i < NSUB; i++) begin
            reg_rd_data_bus[i*32 +: 32] = mem[i][sub_reg_addr[5:2]];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NSUB; i++) begin
            if (reg_wr_en[i]) mem[i][sub_reg_addr[5:2]] <= reg_wr_data;
        end
    end

    // Push the expected outcome and drive a setup phase; returns at the T1 negedge
    task automatic issue_setup(input logic wr, input logic [15:0] addr, input logic [31:0] wd);
        txn_t t;
        int   idx;
        logic [NSUB-1:0] one;
        idx     = int'(addr[15:12]);
        one     = 1;
        t.dir   = wr;
        t.addr  = addr;
        t.wdata = wd;
        t.err   = (idx >= NSUB);
        t.wr_en = (wr && !t.err) ? (one << idx) : '0;
        if (wr) begin
            t.rdata = last_rd;
        end else if (t.err) begin
            t.rdata = 32'h0;
        end else begin
            t.rdata = shadow[idx][addr[5:2]];
        end
        if (!wr) last_rd = t.rdata;
        sbq.push_back(t);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
    endtask

    // Retire the oldest expectation and fold a completed write into the reference copy
    task automatic pop_txn(output txn_t t);
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: empty queue at completion, required 1 entry");
            t = '{dir: 1'b0, addr: 16'h0, wdata: 32'h0, rdata: 32'h0, err: 1'b0, wr_en: '0};
        end else begin
            t = sbq.pop_front();
            if (t.dir && !t.err) shadow[int'(t.addr[15:12])][t.addr[5:2]] = t.wdata;
        end
    endtask

    task automatic go_idle(input int cycles);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        for (int i = 1; i < cycles; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom);
            paddr = 16'($urandom); pwdata = $urandom;
            #1;
            checks++;
            if ({prdata, pready, pslverr, sub_reg_addr, reg_wr_data, reg_wr_en} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got prdata=%h pready=%b pslverr=%b addr=%h wdata=%h wr_en=%b, required all 0",
                         prdata, pready, pslverr, sub_reg_addr, reg_wr_data, reg_wr_en);
            end
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (pready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle_pready: got %b required 0", pready);
            end
        end
    endtask

    task automatic test_write();
        txn_t t;
        issue_setup(1'b1, 16'h1004, 32'hA5A5_0001);
        checks += 4;
        if (reg_wr_en !== 4'b0010) begin errors++; $display("[TB] FAIL write_t1_wr_en: got %b required 0010", reg_wr_en); end
        if (sub_reg_addr !== 12'h004) begin errors++; $display("[TB] FAIL write_t1_addr: got %h required 004", sub_reg_addr); end
        if (reg_wr_data !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL write_t1_data: got %h required a5a50001", reg_wr_data); end
        if (pready !== 1'b0) begin errors++; $display("[TB] FAIL write_t1_pready: got %b required 0", pready); end
        @(negedge clk);
        pop_txn(t);
        checks += 4;
        if (pready !== 1'b1) begin errors++; $display("[TB] FAIL write_t2_pready: got %b required 1", pready); end
        if (pslverr !== 1'b0) begin errors++; $display("[TB] FAIL write_t2_pslverr: got %b required 0", pslverr); end
        if (reg_wr_en !== '0) begin errors++; $display("[TB] FAIL write_t2_wr_en: got %b required 0000", reg_wr_en); end
        if (prdata !== t.rdata) begin errors++; $display("[TB] FAIL write_prdata_hold: got %h required %h", prdata, t.rdata); end
    endtask

    task automatic test_read();
        txn_t t;
        issue_setup(1'b0, 16'h2008, 32'hFFFF_FFFF);
        checks += 2;
        if (reg_wr_en !== '0) begin errors++; $display("[TB] FAIL read_t1_wr_en: got %b required 0000", reg_wr_en); end
        if (sub_reg_addr !== 12'h008) begin errors++; $display("[TB] FAIL read_t1_addr: got %h required 008", sub_reg_addr); end
        @(negedge clk);
        pop_txn(t);
        checks += 4;
        if (pready !== 1'b1) begin errors++; $display("[TB] FAIL read_t2_pready: got %b required 1", pready); end
        if (prdata !== t.rdata) begin errors++; $display("[TB] FAIL read_t2_prdata: got %h required %h", prdata, t.rdata); end
        if (pslverr !== 1'b0) begin errors++; $display("[TB] FAIL read_t2_pslverr: got %b required 0", pslverr); end
        if (reg_wr_en !== '0) begin errors++; $display("[TB] FAIL read_t2_wr_en: got %b required 0000", reg_wr_en); end
        go_idle(2);
    endtask

    task automatic test_unmapped();
        txn_t t;
        for (int k = 0; k < 2; k++) begin
            issue_setup(k == 1, 16'h5000, 32'h1234_5678);
            checks++;
            if (reg_wr_en !== '0) begin errors++; $display("[TB] FAIL unmapped%0d_t1_wr_en: got %b required 0000", k, reg_wr_en); end
            @(negedge clk);
            pop_txn(t);
            checks += 4;
            if (pready !== 1'b1) begin errors++; $display("[TB] FAIL unmapped%0d_pready: got %b required 1", k, pready); end
            if (pslverr !== (t.err & ERR_EN)) begin errors++; $display("[TB] FAIL unmapped%0d_pslverr: got %b required %b", k, pslverr, t.err & ERR_EN); end
            if (prdata !== t.rdata) begin errors++; $display("[TB] FAIL unmapped%0d_prdata: got %h required %h", k, prdata, t.rdata); end
            if (reg_wr_en !== '0) begin errors++; $display("[TB] FAIL unmapped%0d_t2_wr_en: got %b required 0000", k, reg_wr_en); end
            go_idle(1);
        end
    endtask

    task automatic test_back_to_back();
        txn_t t;
        issue_setup(1'b1, 16'h0000, 32'h0000_0001);
        checks++;
        if (reg_wr_en !== 4'b0001) begin errors++; $display("[TB] FAIL b2b_write_wr_en: got %b required 0001", reg_wr_en); end
        @(negedge clk);
        pop_txn(t);
        checks++;
        if (pready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_write_pready: got %b required 1", pready); end
        issue_setup(1'b0, 16'h0000, 32'h0);
        checks++;
        if (pready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_t4_pready: got %b required 0", pready); end
        @(negedge clk);
        pop_txn(t);
        checks += 2;
        if (pready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_t5_pready: got %b required 1", pready); end
        if (prdata !== t.rdata) begin errors++; $display("[TB] FAIL b2b_t5_prdata: got %h required %h", prdata, t.rdata); end
        go_idle(2);
    endtask

    task automatic test_reset_mid();
        txn_t t;
        issue_setup(1'b1, 16'h3010, 32'hCAFE_F00D);
        checks++;
        if (reg_wr_en !== 4'b1000) begin errors++; $display("[TB] FAIL rstmid_pulse: got %b required 1000", reg_wr_en); end
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (reg_wr_en !== '0) begin errors++; $display("[TB] FAIL rstmid_wr_en_drop: got %b required 0000", reg_wr_en); end
        if (pready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pready: got %b required 0", pready); end
        sbq.delete();
        last_rd = 32'h0;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_after_pready: got %b required 0", pready); end
        end
        issue_setup(1'b0, 16'h3010, 32'h0);
        @(negedge clk);
        pop_txn(t);
        checks += 2;
        if (pready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_read_pready: got %b required 1", pready); end
        if (prdata !== t.rdata) begin errors++; $display("[TB] FAIL rstmid_read_prdata: got %h required %h", prdata, t.rdata); end
        go_idle(2);
    endtask

    task automatic test_abort();
        txn_t t;
        issue_setup(1'b0, 16'h1004, 32'h0);
        psel = 1'b0; penable = 1'b0;
        t = sbq.pop_back();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pready !== 1'b0) begin errors++; $display("[TB] FAIL abort_pready: got %b required 0", pready); end
        end
    endtask

    initial begin
        for (int i = 0; i < NSUB; i++) begin
            for (int k = 0; k < 16; k++) begin
                mem[i][k]    = 32'hDEAD_0000 | (i << 8) | k;
                shadow[i][k] = 32'hDEAD_0000 | (i << 8) | k;
            end
        end
        mem[2][2]    = 32'h0000_0002;
        shadow[2][2] = 32'h0000_0002;
        last_rd = 32'h0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        $display("[TB] start, pslverr reporting %0d", ERR_EN);
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_apb_bridge.md
# reg_apb_bridge

APB3 slave front-end that initiates all accesses to the register sub-blocks of the register bank. It decodes the host address into a sub-block index and a 12-bit sub-register address. It drives one write-enable per sub-block plus the shared address/data lines, and returns the selected sub-block's read data to the host with a fixed single wait state. It sits between the system APB interconnect and the register sub-blocks.

## Interface
- NSUB, 4: number of register sub-blocks attached, 1..16; sub-block i owns host window i*0x1000..i*0x1000+0xFFF.
- clk  in  1  block clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  16  APB byte address; [15:12] sub-block index, [11:0] sub-register address.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data, registered.
- pready  out  1  APB ready, registered.
- pslverr  out  1  APB error, registered.
- sub_reg_addr  out  12  sub-register address to all sub-blocks, registered.
- reg_wr_data  out  32  write data to all sub-blocks, registered.
- reg_wr_en  out  NSUB  one-hot write enable, bit i to sub-block i, registered.
- reg_rd_data_bus  in  32*NSUB  sub-block read data, bits [32i+31:32i] from sub-block i, combinational from sub_reg_addr.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: on psel=1 && penable=0 (setup phase): latch paddr[11:0] into sub_reg_addr, pwdata into reg_wr_data, paddr[15:12] into idx, pwrite into dir; err = (idx >= NSUB). Go ISSUE. Any other input combination: stay IDLE. penable=1 without a prior setup is ignored.
- ISSUE: reg_wr_en[idx]=1 for exactly this cycle if dir=1 and err=0, else all zero. On a read with err=0, capture reg_rd_data_bus slice idx into prdata at end of cycle. On a read with err=1, capture prdata=0. Go RESP. If psel=0 in ISSUE: abort, go IDLE, no RESP. A write pulse already issued is not undone.
- RESP: pready=1, pslverr per Configuration. Go IDLE unconditionally.
- prdata holds its last value outside RESP. It is updated only on reads and is unchanged by writes.
- sub_reg_addr and reg_wr_data hold their last value until the next setup phase.
- Reset values: prdata=0, pready=0, pslverr=0, sub_reg_addr=0, reg_wr_data=0, reg_wr_en=0, state IDLE.
- Reset mid-transaction: all outputs return to reset values asynchronously, including any active reg_wr_en pulse. The FSM returns to IDLE. The host transaction is lost.

## Timing
- T0 setup (psel=1, penable=0).
- T1 ISSUE: sub_reg_addr and reg_wr_data are valid, and reg_wr_en pulses on writes.
- T2 RESP: pready=1 and prdata valid; the transfer completes at the T2 edge.
- Every access takes exactly one wait state (access phase = 2 cycles).
- Back-to-back: the next setup phase may occur at T3, giving one transfer per 3 cycles.
- The sub-block samples the write at the T1→T2 edge, so a read of the same address issued immediately after returns the new value.

## Configuration
- REG_BRIDGE_PSLVERR_EN defined: pslverr=1 in RESP for any access with err=1. The write is suppressed and read data is 0.
- Not defined: pslverr is held at 0. Unmapped accesses still suppress the write and return 0; the host receives a normal completion.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0; release, idle 5 cycles → pready stays 0.
- Write paddr=0x1004, pwdata=0xA5A5_0001 (NSUB=4) → at T1, reg_wr_en=4'b0010 for 1 cycle, sub_reg_addr=0x004, reg_wr_data=0xA5A5_0001; at T2, pready=1, pslverr=0.
- Read paddr=0x2008 with slice 2 = 0x0000_0002 → at T2, prdata=0x0000_0002, pready=1; reg_wr_en stays 0 throughout.
- Read and write to paddr=0x5000 (unmapped) → no reg_wr_en; prdata=0; pslverr=1 with REG_BRIDGE_PSLVERR_EN, 0 without.
- Back-to-back write 0x000=1 then read 0x000 with setup at T3 → the read completes at T5 with prdata=1.
- Assert rst_n=0 during ISSUE of a write → reg_wr_en drops immediately, pready never asserts, FSM IDLE after release.
